mem_arbiter: RTL
================

# mem_arbiter

Single-port byte-wide RAM arbiter and sequencer for the pipelined RISC-V core. It shares the 128 KiB synchronous RAM between the instruction-fetch stage and the memory (load/store) stage. Each request is turned into a sequence of 1, 2 or 4 byte accesses, and read bytes are assembled little-endian into a 32-bit result. Sits between IF/MEM and the `ram` instance; replaces IF's direct connection to the RAM.

## Interface
Parameters:
- RAM_ADDR_WIDTH, 17, RAM byte-address width; fixed for the 128 KiB RAM.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when low, all internal state holds.
- if_req_i  in  1  IF requests a 4-byte instruction read; held until if_done_o.
- if_addr_i  in  32  IF byte address.
- if_done_o  out  1  one-cycle pulse; if_data_o valid in the same cycle.
- if_data_o  out  32  fetched instruction, little-endian.
- mem_req_i  in  1  MEM request; held until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_len_i  in  2  00 = 1 byte, 01 = 2 bytes, 10 or 11 = 4 bytes.
- mem_addr_i  in  32  MEM byte address.
- mem_wdata_i  in  32  store data; byte k = bits [8k+7:8k].
- mem_done_o  out  1  one-cycle pulse; mem_rdata_o valid in the same cycle.
- mem_rdata_o  out  32  load data, zero-extended (MEM performs sign extension).
- ram_a_o  out  RAM_ADDR_WIDTH  RAM address.
- ram_d_o  out  8  RAM write data.
- ram_r_nw_o  out  1  1 = read, 0 = write.
- ram_d_i  in  8  RAM read data, valid one cycle after its address.

## Operation
- FSM states: IDLE, XFER, DONE. Byte counter cnt is 3 bits.
- Sampling and latching:
  - In IDLE, requests are sampled at each rising edge.
  - On a grant, the arbiter latches owner, we, N (byte count), base address and wdata, then enters XFER with cnt=0.
- Priority: MEM beats IF on simultaneous requests. This is fixed priority with no fairness counter; MEM stalls the pipeline, so IF cannot starve indefinitely.
- XFER:
  - Each cycle drives ram_a_o = (base + cnt)[RAM_ADDR_WIDTH-1:0].
  - The sum is 32-bit and truncated, so addresses wrap from 0x1FFFF to 0x00000.
- Read sequence:
  - Issue addresses for cnt = 0..N-1.
  - Byte k is captured from ram_d_i in the cycle after address k, into result bits [8k+7:8k].
  - The result is cleared at grant, so unfetched upper bytes read as 0.
  - After the last byte is captured, go to DONE.
- Write sequence:
  - Per cycle: ram_r_nw_o=0 and ram_d_o = wdata byte cnt.
  - After byte N-1 is issued, go to DONE.
- DONE:
  - Asserts the owner's done for exactly one cycle, with data valid.
  - Non-owner done stays 0.
  - Requests are not sampled in DONE, so a requester dropping req after done is never re-granted. Next state is IDLE.
- Outputs outside XFER: ram_r_nw_o=1, ram_d_o=0. ram_a_o holds its last value; this is don't-care for reads.
- if_data_o / mem_rdata_o hold their last value between transactions.
- All outputs are registered.

## Timing
- Reset values: state=IDLE, cnt=0, if_done_o=0, mem_done_o=0, if_data_o=0, mem_rdata_o=0, ram_a_o=0, ram_d_o=0, ram_r_nw_o=1.
- Request sampled at edge ending cycle T. Address for byte k is on ram_a_o during cycle T+1+k.
- Read latency: done during cycle T+N+2. A 4-byte IF fetch therefore gives done at T+6.
- Write latency: byte k is written at the edge ending T+1+k; done during T+N+1.
- Earliest next grant: sampled at the edge ending the first IDLE cycle after DONE.
- rdy=0:
  - State, cnt, latched request and all outputs freeze.
  - During a write, the same byte and data are presented again, which is benign.
  - Total latency grows by exactly the number of rdy-low cycles.
  - A done pulse frozen by rdy=0 stays high until rdy returns, then lasts one more cycle.
- rst mid-transfer:
  - Next cycle is IDLE with reset output values; no further RAM writes occur.
  - The partially written word is not rolled back.
  - Pending reqs are re-sampled after reset is released.
- Changes to requester inputs after grant are ignored until the next grant.

## Test plan
- IF fetch, RAM[0..3] = 13 05 10 00, if_req at addr 0x0 → if_done_o pulses at T+6 with if_data_o = 0x00100513. Addresses seen are 0,1,2,3 with ram_r_nw_o=1 throughout.
- if_req and mem_req (load, len=10, addr 0x100, RAM = EF BE AD DE) asserted in the same cycle → MEM served first: mem_rdata_o = 0xDEADBEEF at T+6. IF is then granted one cycle after DONE, and no done pulse overlaps.
- MEM store len=01, addr 0x20, wdata 0x12345678 → RAM[0x20]=78, RAM[0x21]=56, RAM[0x22..] unchanged, mem_done_o at T+3. A following 4-byte load of 0x20 with RAM[0x22..0x23]=00 returns 0x00005678.
- Wrap-around: 4-byte load at 0x1FFFE → ram_a_o sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; data assembled from those bytes.
- rdy dropped for 3 cycles during byte 2 of an IF fetch → if_done_o at T+9 with correct data; no duplicated or skipped addresses.
- rst pulsed after byte 1 of a 4-byte store → only bytes 0–1 are written, ram_r_nw_o=1 the cycle after reset, no done pulse, and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF/MEM request ports and the byte-wide RAM port of the memory arbiter.
interface mem_arbiter_if #(parameter int RAM_ADDR_WIDTH = 17);
  logic if_req_i, if_done_o, mem_req_i, mem_we_i, mem_done_o, ram_r_nw_o;
  logic [1:0] mem_len_i;
  logic [31:0] if_addr_i, if_data_o, mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [RAM_ADDR_WIDTH-1:0] ram_a_o;
  logic [7:0] ram_d_o, ram_d_i;
  modport slave (
    input if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_d_i,
    output if_done_o, if_data_o, mem_done_o, mem_rdata_o, ram_a_o, ram_d_o, ram_r_nw_o
  );
  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_d_i,
    input if_done_o, if_data_o, mem_done_o, mem_rdata_o, ram_a_o, ram_d_o, ram_r_nw_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM between IF and MEM, sequencing 1/2/4-byte accesses little-endian.
module mem_arbiter #(parameter int RAM_ADDR_WIDTH = 17) (
  input logic clk,
  input logic rst,
  input logic rdy,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state_q;
  logic [2:0] cnt_q, n_q, nc, g_n;
  logic [1:0] cp;
  logic owner_q, we_q, stall_q, g_mem, g_we, last;
  logic [7:0] hold_q, rbyte;
  logic [31:0] base_q, wdata_q, res_q, res_d, g_addr, g_wdata;
  logic [RAM_ADDR_WIDTH-1:0] nxt_a;
  always_comb begin
    g_mem = bus.mem_req_i;
    g_we = g_mem & bus.mem_we_i;
    g_n = !g_mem ? 3'd4 : bus.mem_len_i == 2'd0 ? 3'd1 : bus.mem_len_i == 2'd1 ? 3'd2 : 3'd4;
    g_addr = g_mem ? bus.mem_addr_i : bus.if_addr_i;
    g_wdata = g_mem ? bus.mem_wdata_i : 32'd0;
    nc = cnt_q + 3'd1;
    cp = 2'(cnt_q - 3'd1);
    nxt_a = RAM_ADDR_WIDTH'(base_q + 32'(nc));
    last = we_q ? nc == n_q : cnt_q == n_q;
    // RAM keeps running while stalled, so the byte that arrived on the first stalled cycle is kept
    rbyte = stall_q ? hold_q : bus.ram_d_i;
    res_d = res_q;
    res_d[{cp, 3'b000} +: 8] = rbyte;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      base_q <= '0;
      wdata_q <= '0;
      res_q <= '0;
      stall_q <= 1'b0;
      hold_q <= '0;
      bus.if_done_o <= 1'b0;
      bus.mem_done_o <= 1'b0;
      bus.if_data_o <= '0;
      bus.mem_rdata_o <= '0;
      bus.ram_a_o <= '0;
      bus.ram_d_o <= '0;
      bus.ram_r_nw_o <= 1'b1;
    end else begin
      stall_q <= !rdy;
      if (!stall_q) hold_q <= bus.ram_d_i;
      if (rdy) begin
        case (state_q)
          IDLE: if (bus.mem_req_i || bus.if_req_i) begin
            state_q <= XFER;
            cnt_q <= '0;
            owner_q <= g_mem;
            we_q <= g_we;
            n_q <= g_n;
            base_q <= g_addr;
            wdata_q <= g_wdata;
            res_q <= '0;
            bus.ram_a_o <= g_addr[RAM_ADDR_WIDTH-1:0];
            bus.ram_r_nw_o <= !g_we;
            bus.ram_d_o <= g_we ? g_wdata[7:0] : 8'd0;
          end
          XFER: begin
            if (!we_q && cnt_q != 3'd0) res_q <= res_d;
            bus.ram_d_o <= we_q && !last ? wdata_q[{nc[1:0], 3'b000} +: 8] : 8'd0;
            if (last) begin
              state_q <= DONE;
              bus.ram_r_nw_o <= 1'b1;
              bus.mem_done_o <= owner_q;
              bus.if_done_o <= !owner_q;
              if (owner_q && !we_q) bus.mem_rdata_o <= res_d;
              if (!owner_q) bus.if_data_o <= res_d;
            end else begin
              cnt_q <= nc;
              if (nc < n_q) bus.ram_a_o <= nxt_a;
            end
          end
          default: begin
            state_q <= IDLE;
            bus.if_done_o <= 1'b0;
            bus.mem_done_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
